// File: rtl/mem_controller.sv
// Responder side of the CPU memory handshake: runs one request per MIO_EN
// against an asynchronous SRAM with programmable wait states or on-chip I/O.
module mem_controller #(
    parameter logic [3:0]  WAIT_STATES = 4'd2,
    parameter logic [15:0] IO_BASE     = 16'hFE00
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Address,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        R,
    output logic [15:0] SRAM_ADDR,
    output logic [15:0] SRAM_D_OUT,
    input  logic [15:0] SRAM_D_IN,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    input  logic [15:0] Switches,
    output logic [15:0] Display
);

    localparam logic [15:0] IO_SWITCHES = IO_BASE;
    localparam logic [15:0] IO_DISPLAY  = IO_BASE + 16'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  count_r;
    logic        rw_r;
    logic        is_io_s;
    logic [15:0] io_rdata_s;

    // Address decode and I/O read mux for the request currently presented.
    always_comb begin
        is_io_s    = (Address >= IO_BASE);
        io_rdata_s = 16'h0000;
        if (Address == IO_SWITCHES) begin
            io_rdata_s = Switches;
        end else if (Address == IO_DISPLAY) begin
            io_rdata_s = Display;
        end else begin
            io_rdata_s = 16'h0000;
        end
    end

    // Handshake FSM; every output is a register updated here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            count_r    <= 4'd0;
            rw_r       <= 1'b0;
            R          <= 1'b0;
            Data_Out   <= 16'h0000;
            SRAM_ADDR  <= 16'h0000;
            SRAM_D_OUT <= 16'h0000;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            Display    <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    R <= 1'b0;
                    if (MIO_EN) begin
                        rw_r <= R_W;
                        if (is_io_s) begin
                            // I/O completes on the request edge itself.
                            state_r <= DONE;
                            if (R_W) begin
                                if (Address == IO_DISPLAY) begin
                                    Display <= Data_In;
                                end else begin
                                    Display <= Display;
                                end
                            end else begin
                                Data_Out <= io_rdata_s;
                            end
                        end else begin
                            state_r   <= ACCESS;
                            count_r   <= WAIT_STATES;
                            SRAM_ADDR <= Address;
                            SRAM_CE_N <= 1'b0;
                            if (R_W) begin
                                SRAM_WE_N  <= 1'b0;
                                SRAM_D_OUT <= Data_In;
                            end else begin
                                SRAM_OE_N <= 1'b0;
                            end
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (count_r == 4'd0) begin
                        if (!rw_r) begin
                            Data_Out <= SRAM_D_IN;
                        end else begin
                            Data_Out <= Data_Out;
                        end
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle always raises R, so a requester that
                    // dropped MIO_EN early still sees a one-cycle pulse.
                    if (!R) begin
                        R <= 1'b1;
                    end else if (MIO_EN) begin
                        R <= 1'b1;
                    end else begin
                        R       <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    R         <= 1'b0;
                    SRAM_CE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    SRAM_WE_N <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: one instance with two wait states and
// one with zero wait states share every input except MIO_EN.
module tb_mem_controller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        mio0, mio1;
    logic        R_W;
    logic [15:0] Address, Data_In, SRAM_D_IN, Switches;

    logic [15:0] dout0, saddr0, sdout0, disp0;
    logic        r0, ce0, oe0, we0;
    logic [15:0] dout1, saddr1, sdout1, disp1;
    logic        r1, ce1, oe1, we1;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    mem_controller #(.WAIT_STATES(4'd2), .IO_BASE(16'hFE00)) dut0 (
        .Clk(Clk), .Reset(Reset), .MIO_EN(mio0), .R_W(R_W),
        .Address(Address), .Data_In(Data_In), .Data_Out(dout0), .R(r0),
        .SRAM_ADDR(saddr0), .SRAM_D_OUT(sdout0), .SRAM_D_IN(SRAM_D_IN),
        .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0),
        .Switches(Switches), .Display(disp0)
    );

    mem_controller #(.WAIT_STATES(4'd0), .IO_BASE(16'hFE00)) dut1 (
        .Clk(Clk), .Reset(Reset), .MIO_EN(mio1), .R_W(R_W),
        .Address(Address), .Data_In(Data_In), .Data_Out(dout1), .R(r1),
        .SRAM_ADDR(saddr1), .SRAM_D_OUT(sdout1), .SRAM_D_IN(SRAM_D_IN),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oe1), .SRAM_WE_N(we1),
        .Switches(Switches), .Display(disp1)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; mio0 = 1'b0; mio1 = 1'b0; R_W = 1'b0;
        Address = 16'h0000; Data_In = 16'h0000;
        SRAM_D_IN = 16'h0000; Switches = 16'h0000;

        // 1: reset
        cyc(); cyc();
        chk("rst_r", {15'd0, r0}, 16'd0);
        chk("rst_dout", dout0, 16'h0000);
        chk("rst_addr", saddr0, 16'h0000);
        chk("rst_sdout", sdout0, 16'h0000);
        chk("rst_strobes", {13'd0, ce0, oe0, we0}, 16'h0007);
        chk("rst_disp", disp0, 16'h0000);
        Reset = 1'b0;

        // 2: SRAM read 0x3000, two wait states
        Address = 16'h3000; R_W = 1'b0; SRAM_D_IN = 16'hBEEF; mio0 = 1'b1;
        cyc();
        Address = 16'h1111; R_W = 1'b1;
        chk("rd_t0_strobes", {13'd0, ce0, oe0, we0}, 16'h0001);
        chk("rd_t0_addr", saddr0, 16'h3000);
        cyc();
        chk("rd_t1_strobes", {13'd0, ce0, oe0, we0}, 16'h0001);
        chk("rd_t1_addr", saddr0, 16'h3000);
        cyc();
        chk("rd_t2_strobes", {13'd0, ce0, oe0, we0}, 16'h0001);
        chk("rd_t2_r", {15'd0, r0}, 16'd0);
        cyc();
        chk("rd_t3_strobes", {13'd0, ce0, oe0, we0}, 16'h0007);
        chk("rd_t3_r", {15'd0, r0}, 16'd0);
        chk("rd_t3_dout", dout0, 16'hBEEF);
        cyc();
        chk("rd_t4_r", {15'd0, r0}, 16'd1);
        mio0 = 1'b0;
        cyc();
        chk("rd_drop_r", {15'd0, r0}, 16'd0);

        // 3: SRAM write 0x1234 -> 0x0200
        Address = 16'h0200; R_W = 1'b1; Data_In = 16'h1234; mio0 = 1'b1;
        cyc();
        Data_In = 16'hFFFF;
        chk("wr_t0_strobes", {13'd0, ce0, oe0, we0}, 16'h0002);
        chk("wr_t0_addr", saddr0, 16'h0200);
        chk("wr_t0_sdout", sdout0, 16'h1234);
        cyc();
        chk("wr_t1_strobes", {13'd0, ce0, oe0, we0}, 16'h0002);
        cyc();
        chk("wr_t2_strobes", {13'd0, ce0, oe0, we0}, 16'h0002);
        cyc();
        chk("wr_t3_strobes", {13'd0, ce0, oe0, we0}, 16'h0007);
        chk("wr_t3_sdout", sdout0, 16'h1234);
        chk("wr_t3_addr", saddr0, 16'h0200);
        chk("wr_dout_kept", dout0, 16'hBEEF);
        cyc();
        chk("wr_t4_r", {15'd0, r0}, 16'd1);
        mio0 = 1'b0;
        cyc();
        chk("wr_drop_r", {15'd0, r0}, 16'd0);

        // 4: I/O write Display, read Switches, read unmapped
        Address = 16'hFE01; R_W = 1'b1; Data_In = 16'h00AB; mio0 = 1'b1;
        cyc();
        chk("io_wr_disp", disp0, 16'h00AB);
        chk("io_wr_strobes", {13'd0, ce0, oe0, we0}, 16'h0007);
        chk("io_wr_t0_r", {15'd0, r0}, 16'd0);
        cyc();
        chk("io_wr_t1_r", {15'd0, r0}, 16'd1);
        chk("io_wr_dout", dout0, 16'hBEEF);
        mio0 = 1'b0;
        cyc();
        Address = 16'hFE00; R_W = 1'b0; Switches = 16'h5A5A; mio0 = 1'b1;
        cyc();
        chk("io_rd_sw", dout0, 16'h5A5A);
        cyc();
        chk("io_rd_sw_r", {15'd0, r0}, 16'd1);
        mio0 = 1'b0;
        cyc();
        Address = 16'hFE01; mio0 = 1'b1;
        cyc();
        chk("io_rd_disp", dout0, 16'h00AB);
        cyc();
        mio0 = 1'b0;
        cyc();
        Address = 16'hFE07; mio0 = 1'b1;
        cyc();
        chk("io_rd_other", dout0, 16'h0000);
        cyc();
        mio0 = 1'b0;
        cyc();
        chk("io_idle_r", {15'd0, r0}, 16'd0);

        // 5: reset in the middle of a write, then a fresh read
        Address = 16'h0300; R_W = 1'b1; Data_In = 16'h7777; mio0 = 1'b1;
        cyc();
        chk("rstw_t0_we", {15'd0, we0}, 16'd0);
        Reset = 1'b1;
        cyc();
        chk("rstw_we", {15'd0, we0}, 16'd1);
        chk("rstw_ce", {15'd0, ce0}, 16'd1);
        chk("rstw_r", {15'd0, r0}, 16'd0);
        chk("rstw_addr", saddr0, 16'h0000);
        chk("rstw_disp", disp0, 16'h0000);
        Reset = 1'b0; mio0 = 1'b0;
        cyc();
        Address = 16'h1000; R_W = 1'b0; SRAM_D_IN = 16'h1357; mio0 = 1'b1;
        cyc();
        chk("fresh_t0_strobes", {13'd0, ce0, oe0, we0}, 16'h0001);
        cyc(); cyc(); cyc();
        chk("fresh_t3_dout", dout0, 16'h1357);
        chk("fresh_t3_r", {15'd0, r0}, 16'd0);
        cyc();
        chk("fresh_t4_r", {15'd0, r0}, 16'd1);
        mio0 = 1'b0;
        cyc();
        chk("fresh_drop_r", {15'd0, r0}, 16'd0);

        // 6: zero wait states, MIO_EN held after R
        Address = 16'h0040; R_W = 1'b0; SRAM_D_IN = 16'hC0DE; mio1 = 1'b1;
        cyc();
        chk("ws0_t0_strobes", {13'd0, ce1, oe1, we1}, 16'h0001);
        cyc();
        chk("ws0_t1_strobes", {13'd0, ce1, oe1, we1}, 16'h0007);
        chk("ws0_t1_dout", dout1, 16'hC0DE);
        chk("ws0_t1_r", {15'd0, r1}, 16'd0);
        cyc();
        chk("ws0_t2_r", {15'd0, r1}, 16'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ws0_hold_r", {15'd0, r1}, 16'd1);
            chk("ws0_hold_ce", {15'd0, ce1}, 16'd1);
        end
        mio1 = 1'b0;
        cyc();
        chk("ws0_drop_r", {15'd0, r1}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
